// File: rtl/mips32_pipe_core_p.sv
`default_nettype none
// ============================================================================
// Module   : mips32_pipe_core_p
// Brief    : 5-stage in-order MIPS32-subset core with bypass or stall-only mode
// Revision : 1.0 - initial release
// ============================================================================
module mips32_pipe_core_p #(
    parameter int XLEN       = 32,
    parameter int ADDR_W     = 10,
    parameter int RESET_PC   = 0,
    parameter int FORWARD_EN = 1,
    parameter int CNT_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic              dmem_we,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);
    localparam logic [5:0] c_OP_ADD   = 6'b000000, c_OP_SUB  = 6'b000001, c_OP_AND  = 6'b000010;
    localparam logic [5:0] c_OP_OR    = 6'b000100, c_OP_SLT  = 6'b000101, c_OP_MUL  = 6'b000110;
    localparam logic [5:0] c_OP_LW    = 6'b001000, c_OP_SW   = 6'b001001, c_OP_ADDI = 6'b001010;
    localparam logic [5:0] c_OP_SUBI  = 6'b001011, c_OP_SLTI = 6'b001100, c_OP_BNEQZ = 6'b001101;
    localparam logic [5:0] c_OP_BEQZ  = 6'b001110, c_OP_HLT  = 6'b111111;

    logic [XLEN-1:0]   r_rf [32];
    logic [ADDR_W-1:0] r_pc;
    logic              r_fetch_stop, r_halted;
    logic [CNT_W-1:0]  r_retired;

    logic              r_ifid_valid;
    logic [31:0]       r_ifid_ir;
    logic [ADDR_W-1:0] r_ifid_pc;

    logic              r_idex_valid, r_idex_we, r_idex_cnt;
    logic [5:0]        r_idex_op;
    logic [4:0]        r_idex_rs, r_idex_rt, r_idex_dst;
    logic [XLEN-1:0]   r_idex_a, r_idex_b, r_idex_imm;
    logic [ADDR_W-1:0] r_idex_npc;

    logic              r_exmem_valid, r_exmem_we, r_exmem_cnt;
    logic [5:0]        r_exmem_op;
    logic [4:0]        r_exmem_dst;
    logic [XLEN-1:0]   r_exmem_alu, r_exmem_sdata;

    logic              r_memwb_valid, r_memwb_we, r_memwb_cnt, r_memwb_hlt;
    logic [4:0]        r_memwb_dst;
    logic [XLEN-1:0]   r_memwb_wdata;

    // ---------------- ID: decode, register read, hazard detection ----------
    logic [5:0]      w_op;
    logic [4:0]      w_rs, w_rt, w_rd, w_dst;
    logic            w_use_rs, w_use_rt, w_we, w_cnt;
    logic [XLEN-1:0] w_imm, w_rs_val, w_rt_val;
    logic            w_wb_wr, w_hit_ex, w_hit_mem, w_hit_wb, w_hazard, w_stall, w_id_hlt;

    assign w_op  = r_ifid_ir[31:26];
    assign w_rs  = r_ifid_ir[25:21];
    assign w_rt  = r_ifid_ir[20:16];
    assign w_rd  = r_ifid_ir[15:11];
    assign w_imm = XLEN'($signed(r_ifid_ir[15:0]));

    always_comb begin
        w_use_rs = 1'b0;
        w_use_rt = 1'b0;
        w_we     = 1'b0;
        w_cnt    = 1'b1;
        w_dst    = w_rd;
        case (w_op)
            c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_SLT, c_OP_MUL: begin
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
                w_we     = 1'b1;
            end
            c_OP_ADDI, c_OP_SUBI, c_OP_SLTI, c_OP_LW: begin
                w_use_rs = 1'b1;
                w_we     = 1'b1;
                w_dst    = w_rt;
            end
            c_OP_SW: begin
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
            end
            c_OP_BNEQZ, c_OP_BEQZ: w_use_rs = 1'b1;
            c_OP_HLT:              w_cnt    = 1'b1;
            default:               w_cnt    = 1'b0;
        endcase
        // r0 destinations never write and so never feed a bypass or hazard
        if (w_dst == 5'd0) w_we = 1'b0;
    end

    assign w_wb_wr  = r_memwb_valid && r_memwb_we;
    assign w_rs_val = (w_rs == 5'd0) ? '0 :
                      (w_wb_wr && r_memwb_dst == w_rs) ? r_memwb_wdata : r_rf[w_rs];
    assign w_rt_val = (w_rt == 5'd0) ? '0 :
                      (w_wb_wr && r_memwb_dst == w_rt) ? r_memwb_wdata : r_rf[w_rt];

    assign w_hit_ex  = r_idex_valid && r_idex_we &&
                       ((w_use_rs && w_rs == r_idex_dst) || (w_use_rt && w_rt == r_idex_dst));
    assign w_hit_mem = r_exmem_valid && r_exmem_we &&
                       ((w_use_rs && w_rs == r_exmem_dst) || (w_use_rt && w_rt == r_exmem_dst));
    assign w_hit_wb  = r_memwb_valid && r_memwb_we &&
                       ((w_use_rs && w_rs == r_memwb_dst) || (w_use_rt && w_rt == r_memwb_dst));
    assign w_hazard  = (FORWARD_EN != 0) ? (w_hit_ex && r_idex_op == c_OP_LW)
                                         : (w_hit_ex || w_hit_mem || w_hit_wb);

    // ---------------- EX: bypass, ALU, branch resolution --------------------
    logic            w_fa_mem, w_fa_wb, w_fb_mem, w_fb_wb, w_taken;
    logic [XLEN-1:0] w_ex_a, w_ex_b, w_alu;
    logic [ADDR_W-1:0] w_target;

    assign w_fa_mem = (FORWARD_EN != 0) && r_exmem_valid && r_exmem_we &&
                      r_exmem_op != c_OP_LW && r_exmem_dst == r_idex_rs;
    assign w_fa_wb  = (FORWARD_EN != 0) && w_wb_wr && r_memwb_dst == r_idex_rs;
    assign w_fb_mem = (FORWARD_EN != 0) && r_exmem_valid && r_exmem_we &&
                      r_exmem_op != c_OP_LW && r_exmem_dst == r_idex_rt;
    assign w_fb_wb  = (FORWARD_EN != 0) && w_wb_wr && r_memwb_dst == r_idex_rt;
    assign w_ex_a   = w_fa_mem ? r_exmem_alu : (w_fa_wb ? r_memwb_wdata : r_idex_a);
    assign w_ex_b   = w_fb_mem ? r_exmem_alu : (w_fb_wb ? r_memwb_wdata : r_idex_b);

    always_comb begin
        w_alu = '0;
        case (r_idex_op)
            c_OP_ADD:           w_alu = w_ex_a + w_ex_b;
            c_OP_SUB:           w_alu = w_ex_a - w_ex_b;
            c_OP_AND:           w_alu = w_ex_a & w_ex_b;
            c_OP_OR:            w_alu = w_ex_a | w_ex_b;
            c_OP_SLT:           w_alu = XLEN'($signed(w_ex_a) < $signed(w_ex_b));
            c_OP_MUL:           w_alu = w_ex_a * w_ex_b;
            c_OP_ADDI, c_OP_LW, c_OP_SW: w_alu = w_ex_a + r_idex_imm;
            c_OP_SUBI:          w_alu = w_ex_a - r_idex_imm;
            c_OP_SLTI:          w_alu = XLEN'($signed(w_ex_a) < $signed(r_idex_imm));
            default:            w_alu = '0;
        endcase
    end

    assign w_taken  = r_idex_valid && ((r_idex_op == c_OP_BEQZ  && w_ex_a == '0) ||
                                       (r_idex_op == c_OP_BNEQZ && w_ex_a != '0));
    assign w_target = r_idex_npc + ADDR_W'(r_idex_imm);
    // a taken branch squashes the ID instruction, so its stall/halt requests are void
    assign w_stall  = r_ifid_valid && w_hazard && !w_taken;
    assign w_id_hlt = r_ifid_valid && w_op == c_OP_HLT && !w_taken;

    // ---------------- state update -----------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc          <= ADDR_W'(RESET_PC);
            r_fetch_stop  <= 1'b0;
            r_halted      <= 1'b0;
            r_retired     <= '0;
            r_ifid_valid  <= 1'b0;
            r_idex_valid  <= 1'b0;
            r_exmem_valid <= 1'b0;
            r_memwb_valid <= 1'b0;
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else if (!r_halted) begin
            if (w_taken) begin
                r_pc         <= w_target;
                r_ifid_valid <= 1'b0;
            end else if (!w_stall) begin
                if (w_id_hlt || r_fetch_stop) begin
                    r_ifid_valid <= 1'b0;
                end else begin
                    r_ifid_valid <= 1'b1;
                    r_ifid_ir    <= imem_rdata;
                    r_ifid_pc    <= r_pc;
                    r_pc         <= r_pc + ADDR_W'(1);
                end
            end
            if (w_id_hlt) r_fetch_stop <= 1'b1;

            r_idex_valid <= r_ifid_valid && !w_taken && !w_stall;
            r_idex_op    <= w_op;
            r_idex_rs    <= w_rs;
            r_idex_rt    <= w_rt;
            r_idex_dst   <= w_dst;
            r_idex_we    <= w_we;
            r_idex_cnt   <= w_cnt;
            r_idex_a     <= w_rs_val;
            r_idex_b     <= w_rt_val;
            r_idex_imm   <= w_imm;
            r_idex_npc   <= r_ifid_pc + ADDR_W'(1);

            r_exmem_valid <= r_idex_valid;
            r_exmem_op    <= r_idex_op;
            r_exmem_dst   <= r_idex_dst;
            r_exmem_we    <= r_idex_we;
            r_exmem_cnt   <= r_idex_cnt;
            r_exmem_alu   <= w_alu;
            r_exmem_sdata <= w_ex_b;

            r_memwb_valid <= r_exmem_valid;
            r_memwb_dst   <= r_exmem_dst;
            r_memwb_we    <= r_exmem_we;
            r_memwb_cnt   <= r_exmem_cnt;
            r_memwb_hlt   <= r_exmem_op == c_OP_HLT;
            r_memwb_wdata <= (r_exmem_op == c_OP_LW) ? dmem_rdata : r_exmem_alu;

            if (w_wb_wr) r_rf[r_memwb_dst] <= r_memwb_wdata;
            if (r_memwb_valid && r_memwb_cnt && r_retired != '1) r_retired <= r_retired + CNT_W'(1);
            if (r_memwb_valid && r_memwb_hlt) r_halted <= 1'b1;
        end
    end

    assign imem_addr  = r_pc;
    assign dmem_addr  = ADDR_W'(r_exmem_alu);
    assign dmem_wdata = r_exmem_sdata;
    assign dmem_we    = r_exmem_valid && r_exmem_op == c_OP_SW && !r_halted && !reset;
    assign halted     = r_halted;
    assign retired    = r_retired;
endmodule
`default_nettype wire

// File: tb/tb_mips32_pipe_core_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips32_pipe_core_p
// Brief    : directed bench running bypass, stall-only and 2-bit-counter cores
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips32_pipe_core_p;
    localparam logic [5:0] c_ADD = 6'd0, c_SUB = 6'd1, c_AND = 6'd2, c_OR = 6'd4, c_SLT = 6'd5;
    localparam logic [5:0] c_MUL = 6'd6, c_LW = 6'd8, c_SW = 6'd9, c_ADDI = 6'd10, c_SUBI = 6'd11;
    localparam logic [5:0] c_SLTI = 6'd12, c_BEQZ = 6'd14;
    localparam logic [31:0] c_NOP = 32'hF800_0000;
    localparam logic [31:0] c_HLT = 32'hFC00_0000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic [31:0] imem   [0:1023];
    logic [31:0] dmem_f [0:1023];
    logic [31:0] dmem_n [0:1023];
    logic [31:0] dmem_s [0:1023];
    logic [31:0] prog [$];

    logic [9:0]  ia_f, ia_n, ia_s, da_f, da_n, da_s;
    logic [31:0] dw_f, dw_n, dw_s, rd_f, rd_n, rd_s, ret_f, ret_n;
    logic [1:0]  ret_s;
    logic        we_f, we_n, we_s, hal_f, hal_n, hal_s;
    int          wecnt_f, wecnt_n;
    logic [9:0]  fa_f;
    logic [31:0] fd_f;

    assign rd_f = dmem_f[da_f];
    assign rd_n = dmem_n[da_n];
    assign rd_s = dmem_s[da_s];

    mips32_pipe_core_p #(.FORWARD_EN(1)) u_fwd (
        .clock(clock), .reset(reset), .imem_addr(ia_f), .imem_rdata(imem[ia_f]),
        .dmem_addr(da_f), .dmem_wdata(dw_f), .dmem_we(we_f), .dmem_rdata(rd_f),
        .halted(hal_f), .retired(ret_f));
    mips32_pipe_core_p #(.FORWARD_EN(0)) u_nofwd (
        .clock(clock), .reset(reset), .imem_addr(ia_n), .imem_rdata(imem[ia_n]),
        .dmem_addr(da_n), .dmem_wdata(dw_n), .dmem_we(we_n), .dmem_rdata(rd_n),
        .halted(hal_n), .retired(ret_n));
    mips32_pipe_core_p #(.FORWARD_EN(1), .CNT_W(2)) u_sat (
        .clock(clock), .reset(reset), .imem_addr(ia_s), .imem_rdata(imem[ia_s]),
        .dmem_addr(da_s), .dmem_wdata(dw_s), .dmem_we(we_s), .dmem_rdata(rd_s),
        .halted(hal_s), .retired(ret_s));

    // data memories take stores mid-cycle, when the strobe is settled
    always @(negedge clock) begin
        if (reset) begin
            wecnt_f = 0;
            wecnt_n = 0;
        end
        if (we_f) begin
            dmem_f[da_f] = dw_f;
            wecnt_f++;
            if (wecnt_f == 1) begin
                fa_f = da_f;
                fd_f = dw_f;
            end
        end
        if (we_n) begin
            dmem_n[da_n] = dw_n;
            wecnt_n++;
        end
        if (we_s) dmem_s[da_s] = dw_s;
    end

    function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction
    function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start();
        @(posedge clock);
        #1 reset = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            imem[i]   = c_NOP;
            dmem_f[i] = '0;
            dmem_n[i] = '0;
            dmem_s[i] = '0;
        end
        for (int i = 0; i < prog.size(); i++) imem[i] = prog[i];
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic preset(input int addr, input logic [31:0] val);
        dmem_f[addr] = val;
        dmem_n[addr] = val;
        dmem_s[addr] = val;
    endtask

    // edges counted from reset release; cycle 1 is the edge that latches the first fetch
    task automatic run_to_halt(input int budget, output int cf, output int cn);
        cf = 0;
        cn = 0;
        for (int c = 1; c <= budget && (cf == 0 || cn == 0 || !hal_s); c++) begin
            @(posedge clock);
            @(negedge clock);
            if (hal_f && cf == 0) cf = c;
            if (hal_n && cn == 0) cn = c;
        end
        chk("halt_in_budget", {31'd0, cf != 0 && cn != 0 && hal_s}, 32'd1);
    endtask

    int cf, cn;
    logic [31:0] exp5 [10];

    initial begin
        // 1: independent ALU chain, bypass timing, saturating counter
        prog = '{ri(c_ADDI, 1, 0, 10), ri(c_ADDI, 2, 0, 20), rr(c_ADD, 3, 1, 2),
                 ri(c_SW, 3, 0, 0), c_HLT};
        start();
        @(negedge clock);
        chk("rst_pc", {22'd0, ia_f}, 32'd0);
        chk("rst_retired", ret_f, 32'd0);
        chk("rst_halted", {31'd0, hal_f}, 32'd0);
        chk("rst_we", {31'd0, we_f}, 32'd0);
        run_to_halt(300, cf, cn);
        chk("t1_cycles_fwd", cf, 32'd9);
        chk("t1_cycles_nofwd", cn, 32'd15);
        chk("t1_r3_fwd", dmem_f[0], 32'd30);
        chk("t1_r3_nofwd", dmem_n[0], 32'd30);
        chk("t1_retired", ret_f, 32'd5);
        chk("t1_retired_sat", {30'd0, ret_s}, 32'd3);
        repeat (3) @(negedge clock);
        chk("t1_frozen_pc", {22'd0, ia_f}, 32'd5);
        chk("t1_frozen_retired", ret_f, 32'd5);
        chk("t1_halted_sticky", {31'd0, hal_f}, 32'd1);

        // 2: load-use interlock, NOPs not counted
        prog = '{ri(c_LW, 1, 0, 0), rr(c_ADD, 2, 1, 1), c_NOP, c_NOP, c_NOP,
                 ri(c_SW, 2, 0, 1), c_HLT};
        start();
        preset(0, 32'd7);
        run_to_halt(300, cf, cn);
        chk("t2_cycles_fwd", cf, 32'd12);
        chk("t2_cycles_nofwd", cn, 32'd14);
        chk("t2_r2_fwd", dmem_f[1], 32'd14);
        chk("t2_r2_nofwd", dmem_n[1], 32'd14);
        chk("t2_retired", ret_f, 32'd4);

        // 3: taken branch squashes a HLT and an ADDI
        prog = '{ri(c_ADDI, 1, 0, 0), ri(c_BEQZ, 0, 1, 2), c_HLT, ri(c_ADDI, 5, 0, 1),
                 ri(c_ADDI, 6, 0, 9), ri(c_SW, 5, 0, 2), ri(c_SW, 6, 0, 3), c_HLT};
        start();
        preset(2, 32'h55);
        run_to_halt(300, cf, cn);
        chk("t3_cycles_fwd", cf, 32'd12);
        chk("t3_cycles_nofwd", cn, 32'd17);
        chk("t3_r5_fwd", dmem_f[2], 32'd0);
        chk("t3_r6_fwd", dmem_f[3], 32'd9);
        chk("t3_r5_nofwd", dmem_n[2], 32'd0);
        chk("t3_r6_nofwd", dmem_n[3], 32'd9);
        chk("t3_retired_fwd", ret_f, 32'd6);
        chk("t3_retired_nofwd", ret_n, 32'd6);

        // 4: store then load through memory
        prog = '{ri(c_ADDI, 2, 0, 16'h1234), ri(c_SW, 2, 0, 5), ri(c_LW, 3, 0, 5),
                 ri(c_SW, 3, 0, 6), c_HLT};
        start();
        run_to_halt(300, cf, cn);
        chk("t4_cycles_fwd", cf, 32'd10);
        chk("t4_cycles_nofwd", cn, 32'd15);
        chk("t4_we_pulses_fwd", wecnt_f, 32'd2);
        chk("t4_we_pulses_nofwd", wecnt_n, 32'd2);
        chk("t4_first_addr", {22'd0, fa_f}, 32'd5);
        chk("t4_first_data", fd_f, 32'h1234);
        chk("t4_r3_fwd", dmem_f[6], 32'h1234);
        chk("t4_r3_nofwd", dmem_n[6], 32'h1234);

        // 5: reset pulse while the SW is in EX, then identical rerun
        start();
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("t5_we_in_reset", {31'd0, we_f | we_n}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("t5_we_after", {31'd0, we_f | we_n}, 32'd0);
        chk("t5_pc", {22'd0, ia_f}, 32'd0);
        chk("t5_retired", ret_f, 32'd0);
        chk("t5_halted", {31'd0, hal_f}, 32'd0);
        chk("t5_mem_untouched", dmem_f[5], 32'd0);
        run_to_halt(300, cf, cn);
        chk("t5_cycles_fwd", cf, 32'd10);
        chk("t5_we_pulses", wecnt_f, 32'd2);
        chk("t5_r3_fwd", dmem_f[6], 32'h1234);
        chk("t5_r3_nofwd", dmem_n[6], 32'h1234);
        chk("t5_retired_end", ret_f, 32'd5);

        // 6: arithmetic corners and r0 write discard
        prog = '{ri(c_ADDI, 1, 0, 256), rr(c_MUL, 1, 1, 1), rr(c_MUL, 4, 1, 1),
                 ri(c_ADDI, 7, 0, -1), ri(c_ADDI, 8, 0, 1), rr(c_SLT, 9, 7, 8),
                 rr(c_SLT, 10, 8, 7), rr(c_SUB, 11, 8, 7), rr(c_AND, 13, 7, 1),
                 rr(c_OR, 14, 8, 1), ri(c_SUBI, 15, 8, 3), ri(c_SLTI, 16, 7, 0),
                 rr(c_ADD, 0, 7, 7), ri(c_SW, 0, 0, 14), ri(c_SW, 1, 0, 10),
                 ri(c_SW, 4, 0, 11), ri(c_SW, 9, 0, 12), ri(c_SW, 10, 0, 13),
                 ri(c_SW, 11, 0, 15), ri(c_SW, 13, 0, 16), ri(c_SW, 14, 0, 17),
                 ri(c_SW, 15, 0, 18), ri(c_SW, 16, 0, 19), c_HLT};
        exp5 = '{32'h0001_0000, 32'd0, 32'd1, 32'd0, 32'd0, 32'd2,
                 32'h0001_0000, 32'h0001_0001, 32'hFFFF_FFFE, 32'd1};
        start();
        for (int a = 10; a < 20; a++) preset(a, 32'hAAAA_AAAA);
        run_to_halt(600, cf, cn);
        for (int a = 10; a < 20; a++) begin
            chk($sformatf("t6_fwd_m%0d", a), dmem_f[a], exp5[a-10]);
            chk($sformatf("t6_nofwd_m%0d", a), dmem_n[a], exp5[a-10]);
        end
        chk("t6_retired_fwd", ret_f, 32'd24);
        chk("t6_retired_nofwd", ret_n, 32'd24);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
